// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: credit-limited FIFO reader feeding a 3-deep in-order skid buffer onto a valid/ready stream
module fifo_stream_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      rd_count,
  output logic [7:0]            uf_count
);
  logic [FIFO_WIDTH-1:0] sb [3];
  logic [FIFO_WIDTH-1:0] nb [3];
  logic [1:0] occ, occ_n, wr_idx;
  logic inflight, pop;
  assign m_valid = occ != 2'd0;
  assign m_data  = m_valid ? sb[0] : '0;
  assign pop     = m_valid & m_ready;
  // a read is only issued when the word it returns is guaranteed a free slot
  assign rd_en   = en & ~fifo_empty & (({1'b0, occ} + {2'b0, inflight}) <= 3'd2) & ~rst;
  assign wr_idx  = occ - {1'b0, pop};
  assign occ_n   = occ + {1'b0, inflight} - {1'b0, pop};
  assign nb[0]   = (inflight && wr_idx == 2'd0) ? fifo_data_out : pop ? sb[1] : sb[0];
  assign nb[1]   = (inflight && wr_idx == 2'd1) ? fifo_data_out : pop ? sb[2] : sb[1];
  assign nb[2]   = (inflight && wr_idx == 2'd2) ? fifo_data_out : sb[2];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= '0;
      inflight <= 1'b0;
      sb       <= '{default: '0};
      rd_count <= '0;
      uf_count <= '0;
    end else begin
      occ      <= occ_n;
      inflight <= rd_en;
      sb       <= nb;
      rd_count <= rd_count + CNT_W'(inflight);
      uf_count <= uf_count + 8'(fifo_underflow && uf_count != 8'hff);
    end
  end
endmodule
